// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, constants and GF(2^8)/S-box helpers
package aes_pkg;

  typedef enum logic [1:0] {S_IDLE, S_KEYEXP, S_ROUND, S_DONE} aes_state_e;

  localparam int AES_NR = 10;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant b this collapses to a few xtime/xor stages.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[31-8*i -: 8] = sbox(w[31-8*i -: 8]);
    return r;
  endfunction

  // State is column-major: byte i = row (i % 4), column (i / 4); byte 0 sits in bits [127:120].
  function automatic logic [7:0] get_byte(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [31:0] get_word(input logic [127:0] s, input int c);
    return s[127-32*c -: 32];
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] data,
  input  logic [127:0] round_key,
  input  logic         final_rnd,
  output logic [127:0] next_data
);

  logic [127:0] sub_key;
  logic [127:0] mixed;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9),
            gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13),
            gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11),
            gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14)};
  endfunction

  // Row r is rotated right by r: output column c takes input column (c - r) mod 4.
  always_comb begin
    sub_key = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_key[127-8*(4*c+r) -: 8] = inv_sbox(get_byte(data, 4*((c-r)&3)+r))
                                      ^ get_byte(round_key, 4*c+r);
      end
    end
  end

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) mixed[127-32*c -: 32] = inv_mix_col(get_word(sub_key, c));
  end

  assign next_data = final_rnd ? sub_key : mixed;

endmodule

// File: rtl/aes128_decrypt_core.sv
// rtl/aes128_decrypt_core.sv - iterative AES-128 inverse cipher; optional key cache via AES_DEC_KEY_CACHE_EN
module aes128_decrypt_core
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);

  if (NR != AES_NR) begin : g_nr_check
    $error("aes128_decrypt_core: only NR = 10 is supported");
  end

  aes_state_e   state, state_d;
  logic [3:0]   rnd;
  logic [127:0] data;
  logic [127:0] pt_q;
  logic [127:0] rk [0:AES_NR];
  logic         accept;
  logic         cache_hit;
  logic [127:0] round_out;

  assign accept = in_valid && (state == S_IDLE);

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cache_key;
  logic         cache_vld;

  assign cache_hit = cache_vld && (key == cache_key);

  // Flag drops while a new key is being expanded so an aborted expansion never looks valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld <= 1'b0;
      cache_key <= '0;
    end else if (accept && !cache_hit) begin
      cache_vld <= 1'b0;
      cache_key <= key;
    end else if (state == S_KEYEXP && rnd == 4'd10) begin
      cache_vld <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (in_valid) state_d = cache_hit ? S_ROUND : S_KEYEXP;
      S_KEYEXP: if (rnd == 4'd10) state_d = S_ROUND;
      S_ROUND:  if (rnd == 4'd0) state_d = S_DONE;
      S_DONE:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Key schedule: one round key per cycle, each derived from its predecessor.
  logic [3:0]   rnd_m1;
  logic [127:0] rk_prev;
  logic [31:0]  w3_sub, nw0, nw1, nw2, nw3;

  assign rnd_m1  = rnd - 4'd1;
  assign rk_prev = rk[rnd_m1];
  assign w3_sub  = sub_word({rk_prev[23:0], rk_prev[31:24]}) ^ {rcon(rnd), 24'h000000};
  assign nw0     = rk_prev[127:96] ^ w3_sub;
  assign nw1     = rk_prev[95:64]  ^ nw0;
  assign nw2     = rk_prev[63:32]  ^ nw1;
  assign nw3     = rk_prev[31:0]   ^ nw2;

  always_ff @(posedge clk) begin
    if (accept)                 rk[0]   <= key;
    else if (state == S_KEYEXP) rk[rnd] <= {nw0, nw1, nw2, nw3};
  end

  aes_inv_round u_inv_round (
    .data      (data),
    .round_key (rk[rnd]),
    .final_rnd (rnd == 4'd0),
    .next_data (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd  <= 4'd0;
      data <= '0;
      pt_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          data <= ciphertext;
          rnd  <= cache_hit ? 4'd10 : 4'd1;
        end
        S_KEYEXP: if (rnd != 4'd10) rnd <= rnd + 4'd1;
        S_ROUND: begin
          if (rnd == 4'd10) data <= data ^ rk[10];
          else              data <= round_out;
          if (rnd == 4'd0) pt_q <= round_out;
          else             rnd  <= rnd - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_KEYEXP) || (state == S_ROUND);
  assign plaintext = pt_q;

endmodule

// File: tb/tb_aes128_decrypt_core.sv
// tb/tb_aes128_decrypt_core.sv - directed vector bench for aes128_decrypt_core
module tb_aes128_decrypt_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic         busy;

  aes128_decrypt_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext),
    .busy       (busy)
  );

  always #5 clk = ~clk;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_RK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    logic [127:0] rk10;
  } vec_t;

  vec_t vecs[5];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model of the key cache, used only to predict latency.
  logic         m_vld = 1'b0;
  logic [127:0] m_key = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int exp_latency(input logic [127:0] k);
    return (CACHE_EN && m_vld && (k == m_key)) ? 11 : 21;
  endfunction

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Full transfer with out_ready high: accept, measure latency, take output, confirm return to IDLE.
  task automatic run_block(input logic [127:0] k, input logic [127:0] ct,
                           input logic [127:0] exp_pt, input string tag);
    int n, lat, exp_lat;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " in_ready before"}, in_ready, 1);
    exp_lat    = exp_latency(k);
    key        = k;
    ciphertext = ct;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " plaintext"}, plaintext, exp_pt);
    m_key = k;
    m_vld = 1'b1;
    @(posedge clk); #1;
    check({tag, " idle after handshake"}, {in_ready, out_valid, busy}, 3'b100);
  endtask

  initial begin
    int lat, exp_lat, rdy_seen;
    vecs[0] = '{C1_KEY, C1_CT, C1_PT, C1_RK};
    vecs[1] = '{B_KEY,  B_CT,  B_PT,  B_RK};
    vecs[2] = '{B_KEY, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                128'h6bc1bee22e409f96e93d7e117393172a, B_RK};
    vecs[3] = '{B_KEY, 128'hf5d3d58503b9699de785895a96fdbaaf,
                128'hae2d8a571e03ac9c9eb76fac45af8e51, B_RK};
    vecs[4] = '{C1_KEY, C1_CT, C1_PT, C1_RK};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    key        = '0;
    ciphertext = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset plaintext", plaintext, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_block(vecs[i].key, vecs[i].ct, vecs[i].pt, $sformatf("vec%0d", i));
      check($sformatf("vec%0d rk10", i), dut.rk[10], vecs[i].rk10);
    end

    // Backpressure: plaintext must hold while out_ready stays low.
    out_ready = 1'b0;
    @(negedge clk);
    check("bp in_ready before", in_ready, 1);
    exp_lat    = exp_latency(C1_KEY);
    key        = C1_KEY;
    ciphertext = C1_CT;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    check("bp latency", lat, exp_lat);
    m_key = C1_KEY;
    m_vld = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold pt %0d", i), plaintext, C1_PT);
      check($sformatf("bp hold flags %0d", i), {in_ready, out_valid}, 2'b01);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release idle", {in_ready, out_valid, busy}, 3'b100);

    // Asynchronous reset mid-block, then a clean C.1 block.
    @(negedge clk);
    key        = B_KEY;
    ciphertext = B_CT;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    check("rst busy before abort", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst plaintext", plaintext, 0);
    m_vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_block(C1_KEY, C1_CT, C1_PT, "post reset C1");

    // in_valid held high with new data while busy: ignored until the first output leaves.
    @(negedge clk);
    exp_lat    = exp_latency(C1_KEY);
    key        = C1_KEY;
    ciphertext = C1_CT;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    key        = B_KEY;
    ciphertext = B_CT;
    lat        = 0;
    rdy_seen   = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (in_ready) rdy_seen++;
    end
    check("hold first latency", lat, exp_lat);
    check("hold first plaintext", plaintext, C1_PT);
    check("hold in_ready while busy", rdy_seen, 0);
    m_key = C1_KEY;
    m_vld = 1'b1;
    @(posedge clk); #1;
    check("hold idle after first", {in_ready, out_valid}, 2'b10);
    exp_lat = exp_latency(B_KEY);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    check("hold second latency", lat, exp_lat);
    check("hold second plaintext", plaintext, B_PT);
    m_key = B_KEY;
    m_vld = 1'b1;
    @(posedge clk); #1;
    check("hold idle after second", {in_ready, out_valid, busy}, 3'b100);

    // Key reuse then key change; latency follows the cache model.
    run_block(C1_KEY, C1_CT, C1_PT, "reuse C1 first");
    run_block(C1_KEY, C1_CT, C1_PT, "reuse C1 second");
    run_block(B_KEY, B_CT, B_PT, "change to B");
    check("final rk10", dut.rk[10], B_RK);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
